// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM states, decode constants, tap count.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_X   = 3'd1,
    FETCH_K   = 3'd2,
    MAC       = 3'd3,
    WRITEBACK = 3'd4
  } conv_state_t;

  localparam logic [3:0] ALU_OP_CONV    = 4'b1111;
  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam int unsigned KSIZE_DEFAULT = 3;

  function automatic int unsigned conv_taps(input int unsigned ksize);
    return ksize * ksize;
  endfunction

  localparam int unsigned TAPS = conv_taps(KSIZE_DEFAULT);

endpackage

// File: rtl/conv_sequencer_if.sv
// Decode, data-memory read port and write-back bundle of the convolution sequencer.
interface conv_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] k_base;
  logic [4:0]        rd_in;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              regwrite_control;
  logic [4:0]        rd_out;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output start, x_base, k_base, rd_in, mem_ack, mem_rdata,
    input  mem_req, mem_addr, busy, regwrite_control, rd_out, wr_data
  );

  modport slave (
    input  start, x_base, k_base, rd_in, mem_ack, mem_rdata,
    output mem_req, mem_addr, busy, regwrite_control, rd_out, wr_data
  );
endinterface

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with clear/enable; result clamps when CONV_SAT_EN is defined,
// otherwise truncates to DATA_W bits.
module conv_mac #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] k,
  output logic        [DATA_W-1:0] result
);
  localparam int unsigned ACC_W = 2 * DATA_W + 4;

  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    acc;

  assign product = x * k;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(product);
    end
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    result = acc[DATA_W-1:0];
    if (acc > SAT_MAX) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (acc < SAT_MIN) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:DATA_W];
  assign result        = acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/conv_sequencer.sv
// Multi-cycle convolution sequencer: fetches window/kernel pairs, accumulates, writes back once.
// Optional result saturation via CONV_SAT_EN (handled in conv_mac).
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned IMG_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  conv_sequencer_if.slave   bus
);
  localparam int unsigned NTAPS = conv_taps(KSIZE);
  localparam int unsigned TAP_W = (NTAPS > 1) ? $clog2(NTAPS + 1) : 1;
  localparam int unsigned RC_W  = (KSIZE > 1) ? $clog2(KSIZE + 1) : 1;

  conv_state_t              state_q;
  logic [ADDR_W-1:0]        x_base_q;
  logic [ADDR_W-1:0]        k_base_q;
  logic [4:0]               rd_q;
  logic [TAP_W-1:0]         tap;
  logic [RC_W-1:0]          row;
  logic [RC_W-1:0]          col;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] k_q;
  logic [ADDR_W-1:0]        x_addr;
  logic [ADDR_W-1:0]        k_addr;
  logic [DATA_W-1:0]        result;
  logic                     accept;

  assign accept = (state_q == IDLE) && bus.start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x_base_q <= '0;
      k_base_q <= '0;
      rd_q     <= '0;
      tap      <= '0;
      row      <= '0;
      col      <= '0;
      x_q      <= '0;
      k_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_base_q <= bus.x_base;
            k_base_q <= bus.k_base;
            rd_q     <= bus.rd_in;
            tap      <= '0;
            row      <= '0;
            col      <= '0;
            state_q  <= FETCH_X;
          end
        end
        FETCH_X: begin
          if (bus.mem_ack) begin
            x_q     <= bus.mem_rdata;
            state_q <= FETCH_K;
          end
        end
        FETCH_K: begin
          if (bus.mem_ack) begin
            k_q     <= bus.mem_rdata;
            state_q <= MAC;
          end
        end
        MAC: begin
          tap <= tap + 1'b1;
          if (col == RC_W'(KSIZE - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          state_q <= (tap == TAP_W'(NTAPS - 1)) ? WRITEBACK : FETCH_X;
        end
        WRITEBACK: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Addresses derive only from registered counters, so they hold steady through ack waits.
  assign x_addr = x_base_q + ADDR_W'(row * IMG_W) + ADDR_W'(col);
  assign k_addr = k_base_q + ADDR_W'(tap);

  conv_mac #(.DATA_W(DATA_W)) u_mac (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (state_q == MAC),
    .x       (x_q),
    .k       (k_q),
    .result  (result)
  );

  assign bus.mem_req          = (state_q == FETCH_X) || (state_q == FETCH_K);
  assign bus.mem_addr         = (state_q == FETCH_X) ? x_addr :
                                (state_q == FETCH_K) ? k_addr : '0;
  assign bus.busy             = (state_q != IDLE);
  assign bus.regwrite_control = (state_q == WRITEBACK);
  assign bus.rd_out           = (state_q == WRITEBACK) ? rd_q : '0;
  assign bus.wr_data          = (state_q == WRITEBACK) ? result : '0;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer (IMG_W=8, KSIZE=3) with a memory responder model.
module tb_conv_sequencer;

  logic clock;
  logic reset_n;

  conv_sequencer_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  conv_sequencer #(.DATA_W(32), .ADDR_W(10), .KSIZE(3), .IMG_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic signed [31:0] mem [1024];
  int win [9];
  int ker [9];

  int xb_m, kb_m;
  int fetch_idx, total_wait, stab_err, addr_err;
  bit rand_delay, spurious;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int win_addr(input int xb, input int t);
    return (xb + (t / 3) * 8 + (t % 3)) % 1024;
  endfunction

  function automatic int fetch_addr(input int idx);
    if (idx % 2 == 0) return win_addr(xb_m, idx / 2);
    return (kb_m + idx / 2) % 1024;
  endfunction

  function automatic logic [31:0] ref_conv(input int xb, input int kb);
    longint acc = 0;
    for (int t = 0; t < 9; t++)
      acc += longint'(mem[win_addr(xb, t)]) * longint'(mem[(kb + t) % 1024]);
`ifdef CONV_SAT_EN
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  task automatic fill(input int xb, input int kb);
    for (int t = 0; t < 9; t++) begin
      mem[win_addr(xb, t)] = win[t];
      mem[(kb + t) % 1024] = ker[t];
    end
  endtask

  // Memory responder: acks after 0 (or random 0-3) wait cycles and tracks address behaviour.
  initial begin
    int wait_left;
    logic [9:0] held;
    bit pending;
    pending = 0;
    wait_left = 0;
    held = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock); #2;
      if (!reset_n) begin
        pending = 0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (!pending) begin
          pending = 1;
          held = bus.mem_addr;
          wait_left = rand_delay ? int'($urandom_range(0, 3)) : 0;
          total_wait += wait_left;
          if (bus.mem_addr !== 10'(fetch_addr(fetch_idx))) addr_err++;
        end else if (bus.mem_addr !== held) begin
          stab_err++;
        end
        if (wait_left == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
          pending = 0;
          fetch_idx++;
        end else begin
          wait_left--;
          bus.mem_ack = 1'b0;
          bus.mem_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        pending = 0;
        bus.mem_ack = spurious;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic run_conv(input logic [9:0] xb, input logic [9:0] kb, input logic [4:0] rd,
                          input logic [31:0] exp_data, input bit extra_starts, input string tag);
    int c, pulses, wb_c, busy_bad;
    logic [31:0] got_d;
    logic [4:0]  got_rd;
    logic        idle_ok;
    @(posedge clock); #1;
    xb_m = int'(xb); kb_m = int'(kb);
    fetch_idx = 0; total_wait = 0; stab_err = 0; addr_err = 0;
    bus.x_base = xb; bus.k_base = kb; bus.rd_in = rd; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    c = 1; pulses = 0; wb_c = 0; busy_bad = 0; idle_ok = 1'b0;
    got_d = '0; got_rd = '0;
    while (c < 400) begin
      if (extra_starts && (c == 5 || c == 28)) begin
        bus.start = 1'b1; bus.x_base = 10'd200; bus.k_base = 10'd300; bus.rd_in = 5'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.regwrite_control) begin
        pulses++;
        wb_c = c; got_d = bus.wr_data; got_rd = bus.rd_out;
        if (!bus.busy) busy_bad++;
      end else if (pulses == 0 && !bus.busy) begin
        busy_bad++;
      end
      if (pulses > 0 && c == wb_c + 1) idle_ok = !bus.busy;
      if (pulses > 0 && c == wb_c + 4) break;
      @(posedge clock); #1;
      c++;
    end
    bus.start = 1'b0;
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_data"}, 64'(got_d), 64'(exp_data));
    chk({tag, "_rd"}, 64'(got_rd), 64'(rd));
    chk({tag, "_cycle"}, 64'(wb_c), 64'(28 + total_wait));
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
    chk({tag, "_idle_after"}, 64'(idle_ok), 64'd1);
    chk({tag, "_addr"}, 64'(addr_err), 64'd0);
    chk({tag, "_stable"}, 64'(stab_err), 64'd0);
  endtask

  initial begin
    rand_delay = 0; spurious = 0;
    fetch_idx = 0; total_wait = 0; stab_err = 0; addr_err = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i % 13 + 1);
    bus.start = 1'b0; bus.x_base = '0; bus.k_base = '0; bus.rd_in = '0;
    reset_n = 1'b0;
    #1;
    chk("reset_mem_req", 64'(bus.mem_req), 64'd0);
    chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_regwrite", 64'(bus.regwrite_control), 64'd0);
    chk("reset_rd_out", 64'(bus.rd_out), 64'd0);
    chk("reset_wr_data", 64'(bus.wr_data), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;

    // Window 1..9 (row stride 8), kernel all ones -> 45.
    win = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    ker = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    fill(0, 64);
    run_conv(10'd0, 10'd64, 5'd5, 32'd45, 1'b0, "sum45");

    // Edge-detect kernel on rows {1,2,3}: 3 * (3 - 1) = 6, then negated window -> -6.
    win = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
    ker = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
    fill(100, 150);
    run_conv(10'd100, 10'd150, 5'd7, 32'd6, 1'b0, "edge_pos");
    for (int i = 0; i < 9; i++) win[i] = -win[i];
    fill(100, 150);
    run_conv(10'd100, 10'd150, 5'd31, 32'hFFFF_FFFA, 1'b0, "edge_neg");

    // Extra start pulses in cycles 5 and 28 must be dropped.
    win = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    ker = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    fill(0, 64);
    run_conv(10'd0, 10'd64, 5'd5, 32'd45, 1'b1, "restart");

    // Reset in cycle 10 of a run, then a clean run must not see stale accumulation.
    @(posedge clock); #1;
    xb_m = 0; kb_m = 64; fetch_idx = 0;
    bus.x_base = 10'd0; bus.k_base = 10'd64; bus.rd_in = 5'd3; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    chk("midrun_busy_before", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrun_mem_req", 64'(bus.mem_req), 64'd0);
    chk("midrun_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midrun_busy", 64'(bus.busy), 64'd0);
    chk("midrun_regwrite", 64'(bus.regwrite_control), 64'd0);
    chk("midrun_rd_out", 64'(bus.rd_out), 64'd0);
    chk("midrun_wr_data", 64'(bus.wr_data), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    run_conv(10'd0, 10'd64, 5'd12, 32'd45, 1'b0, "after_reset");

    // Largest positive operands: wraps to 9, or clamps to the positive limit.
    for (int i = 0; i < 9; i++) begin win[i] = 32'h7FFF_FFFF; ker[i] = 32'h7FFF_FFFF; end
    fill(400, 500);
`ifdef CONV_SAT_EN
    run_conv(10'd400, 10'd500, 5'd1, 32'h7FFF_FFFF, 1'b0, "max_ops");
`else
    run_conv(10'd400, 10'd500, 5'd1, 32'h0000_0009, 1'b0, "max_ops");
`endif

    // Random ack latency, spurious idle acks, and address wrap at the top of memory.
    rand_delay = 1; spurious = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) begin
        win[i] = int'($urandom_range(0, 2000)) - 1000;
        ker[i] = int'($urandom_range(0, 2000)) - 1000;
      end
      fill(1015, 1020);
      run_conv(10'd1015, 10'd1020, 5'(20 + r), ref_conv(1015, 1020), 1'b0, "rand_wrap");
    end
    rand_delay = 0; spurious = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
